// File: rtl/prefix_eval.sv
// Prefix-expression evaluator: scans packed 5-bit tokens last-to-first on a 10-deep stack.
// Optional integer division is enabled by defining PREFIX_EVAL_DIV_EN.
module prefix_eval (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [94:0] in_expr,
    output logic        busy,
    output logic        out_valid,
    output logic [40:0] out,
    output logic        err
);

    localparam logic [3:0] DEPTH = 4'd10;

    typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

    state_t      state_q;
    logic [94:0] expr_q;
    logic [4:0]  len_q;
    logic [4:0]  idx_q;
    logic [3:0]  depth_q;
    logic        flag_q;
    logic        busy_q;
    logic        out_valid_q;
    logic [40:0] out_q;
    logic        err_q;
    logic [40:0] stack_q [10];

    logic [4:0]  len_d;
    logic [4:0]  slot [19];
    logic [4:0]  tok;
    logic        op_legal;
    logic [3:0]  rd_a;
    logic [3:0]  rd_b;
    logic signed [40:0] op_a;
    logic signed [40:0] op_b;
    logic signed [40:0] prod;
    logic        push_en;
    logic [3:0]  wr_addr;
    logic [40:0] wr_data;
    logic [3:0]  depth_d;
    logic        flag_d;

    genvar gi;
    generate
        for (gi = 0; gi < 19; gi++) begin : g_slot
            assign slot[gi] = expr_q[5*gi +: 5];
        end
    endgenerate

    // Length runs up to the highest nonzero slot; an all-zero word still holds one operand 0.
    always_comb begin
        len_d = 5'd1;
        for (int i = 0; i < 19; i++) begin
            if (in_expr[5*i +: 5] != 5'd0) len_d = 5'(i + 1);
        end
    end

    assign tok  = slot[idx_q];
    assign rd_a = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;
    assign rd_b = (depth_q < 4'd2)  ? 4'd0 : depth_q - 4'd2;
    assign op_a = stack_q[rd_a];
    assign op_b = stack_q[rd_b];
    assign prod = op_a * op_b;

`ifdef PREFIX_EVAL_DIV_EN
    logic signed [40:0] quot;
    assign quot     = (op_b == 41'sd0) ? 41'sd0 : op_a / op_b;
    assign op_legal = (tok[3:2] == 2'b00);
`else
    assign op_legal = (tok[3:2] == 2'b00) && (tok[1:0] != 2'b11);
`endif

    always_comb begin
        push_en = 1'b0;
        wr_addr = depth_q;
        wr_data = '0;
        depth_d = depth_q;
        flag_d  = flag_q;
        if (!tok[4]) begin
            if (depth_q == DEPTH) begin
                flag_d = 1'b1;
            end else begin
                push_en = 1'b1;
                wr_data = {37'd0, tok[3:0]};
                depth_d = depth_q + 4'd1;
            end
        end else if (!op_legal || depth_q < 4'd2) begin
            flag_d = 1'b1;
        end else begin
            // Result overwrites the second-popped slot, so the stack shrinks by one.
            push_en = 1'b1;
            wr_addr = rd_b;
            depth_d = depth_q - 4'd1;
            case (tok[1:0])
                2'b00:   wr_data = op_a + op_b;
                2'b01:   wr_data = op_a - op_b;
                2'b10:   wr_data = prod;
                default: begin
`ifdef PREFIX_EVAL_DIV_EN
                    wr_data = quot;
                    if (op_b == 41'sd0) flag_d = 1'b1;
`else
                    wr_data = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == SCAN && push_en) stack_q[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            expr_q      <= '0;
            len_q       <= 5'd1;
            idx_q       <= 5'd0;
            depth_q     <= 4'd0;
            flag_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
            if (out_valid_q) busy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        expr_q  <= in_expr;
                        len_q   <= len_d;
                        idx_q   <= 5'd0;
                        depth_q <= 4'd0;
                        flag_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    depth_q <= depth_d;
                    flag_q  <= flag_d;
                    idx_q   <= idx_q + 5'd1;
                    if (idx_q == len_q - 5'd1) state_q <= OUT;
                end
                OUT: begin
                    out_valid_q <= 1'b1;
                    out_q       <= (depth_q == 4'd1 && !flag_q) ? stack_q[0] : '0;
                    err_q       <= flag_q || (depth_q != 4'd1);
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prefix_eval.sv
// Directed bench for prefix_eval: hand-computed results, latencies, reset abort and busy behaviour.
module tb_prefix_eval;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [94:0] in_expr;
    logic        busy;
    logic        out_valid;
    logic [40:0] out;
    logic        err;

    int total;
    int bad;

    prefix_eval dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_expr   (in_expr),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at #1 after an edge; pulses in_valid and waits (bounded) for the result strobe.
    task automatic send(input logic [94:0] e, output logic [40:0] o, output logic er, output int lat);
        in_expr  = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        o   = '0;
        er  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = c;
                o   = out;
                er  = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_expr = '0;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({busy, out_valid, err, out} !== 44'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b ov=%b err=%b out=%0d, want all 0", busy, out_valid, err, out);
        end
        rst = 1'b0;
        $display("reset checked");
    endtask

    task automatic test_first_after_reset();
        logic [40:0] o; logic er; int lat;
        send(95'({5'h10, 5'h03, 5'h04}), o, er, lat);
        total++;
        if (o !== 41'd7 || er !== 1'b0 || lat != 4) begin
            bad++;
            $display("FAIL first_after_reset: got out=%0d err=%b lat=%0d, want out=7 err=0 lat=4", $signed(o), er, lat);
        end
        $display("first after reset: out=%0d err=%b lat=%0d", $signed(o), er, lat);
    endtask

    task automatic test_vectors();
        logic [94:0] ve [11];
        logic [40:0] vo [11];
        logic        vr [11];
        int          vl [11];
        logic [40:0] o; logic er; int lat;
        ve[0]  = 95'({5'h10, 5'h03, 5'h04});                   vo[0]  = 41'd7;       vr[0]  = 0; vl[0]  = 4;
        ve[1]  = 95'({5'h12, 5'h11, 5'h02, 5'h05, 5'h0F});     vo[1]  = 41'(-45);    vr[1]  = 0; vl[1]  = 6;
`ifdef PREFIX_EVAL_DIV_EN
        ve[2]  = 95'({5'h13, 5'h11, 5'h01, 5'h08, 5'h02});     vo[2]  = 41'(-3);     vr[2]  = 0; vl[2]  = 6;
        ve[3]  = 95'({5'h13, 5'h07, 5'h11, 5'h00, 5'h02});     vo[3]  = 41'(-3);     vr[3]  = 0; vl[3]  = 6;
`else
        ve[2]  = 95'({5'h13, 5'h11, 5'h01, 5'h08, 5'h02});     vo[2]  = 41'd0;       vr[2]  = 1; vl[2]  = 6;
        ve[3]  = 95'({5'h13, 5'h07, 5'h11, 5'h00, 5'h02});     vo[3]  = 41'd0;       vr[3]  = 1; vl[3]  = 6;
`endif
        ve[4]  = 95'({5'h13, 5'h09, 5'h00});                   vo[4]  = 41'd0;       vr[4]  = 1; vl[4]  = 4;
        ve[5]  = 95'd0;                                        vo[5]  = 41'd0;       vr[5]  = 0; vl[5]  = 2;
        ve[6]  = 95'({5'h10, 5'h03});                          vo[6]  = 41'd0;       vr[6]  = 1; vl[6]  = 3;
        ve[7]  = 95'({5'h11, 5'h00, 5'h05});                   vo[7]  = 41'(-5);     vr[7]  = 0; vl[7]  = 4;
        ve[8]  = 95'(5'h14);                                   vo[8]  = 41'd0;       vr[8]  = 1; vl[8]  = 2;
        ve[9]  = 95'({11{5'h01}});                             vo[9]  = 41'd0;       vr[9]  = 1; vl[9]  = 12;
        ve[10] = {{9{5'h10}}, {10{5'h01}}};                    vo[10] = 41'd10;      vr[10] = 0; vl[10] = 20;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            send(ve[i], o, er, lat);
            total++;
            if (o !== vo[i] || er !== vr[i] || lat != vl[i]) begin
                bad++;
                $display("FAIL vector_%0d: got out=%0d err=%b lat=%0d, want out=%0d err=%b lat=%0d",
                         i, $signed(o), er, lat, $signed(vo[i]), vr[i], vl[i]);
            end
            $display("vector %0d: out=%0d err=%b lat=%0d", i, $signed(o), er, lat);
        end
    endtask

    task automatic test_busy();
        logic seen_idle_out;
        @(posedge clk); #1;
        in_expr = 95'({5'h10, 5'h03, 5'h04}); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || out !== 41'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL busy_scan: got busy=%b out=%0d err=%b, want busy=1 out=0 err=0", busy, out, err);
        end
        seen_idle_out = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_at_strobe: got ov=%b busy=%b, want 1 1", out_valid, busy);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out !== 41'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL busy_after: got busy=%b ov=%b out=%0d err=%b, want 0 0 0 0", busy, out_valid, out, err);
        end
        $display("busy sequence checked");
    endtask

    task automatic test_back_to_back();
        logic [40:0] o; logic er; int lat; int strobes;
        // Second in_valid while busy must be ignored; only the first result appears.
        @(posedge clk); #1;
        in_expr = 95'({5'h10, 5'h03, 5'h04}); in_valid = 1'b1;
        @(posedge clk); #1;
        in_expr = 95'({5'h12, 5'h02, 5'h05});
        @(posedge clk); #1;
        in_valid = 1'b0;
        strobes = 0;
        o = '0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid) begin strobes++; o = out; end
            @(posedge clk); #1;
        end
        total++;
        if (strobes != 1 || o !== 41'd7) begin
            bad++;
            $display("FAIL ignore_busy: got strobes=%0d out=%0d, want strobes=1 out=7", strobes, $signed(o));
        end
        send(95'({5'h11, 5'h09, 5'h02}), o, er, lat);
        @(posedge clk); #1;
        send(95'({5'h12, 5'h03, 5'h04}), o, er, lat);
        total++;
        if (o !== 41'd12 || er !== 1'b0 || lat != 4) begin
            bad++;
            $display("FAIL back_to_back: got out=%0d err=%b lat=%0d, want out=12 err=0 lat=4", $signed(o), er, lat);
        end
        $display("back to back: out=%0d err=%b lat=%0d", $signed(o), er, lat);
    endtask

    task automatic test_reset_abort();
        logic [40:0] o; logic er; int lat; int strobes;
        @(posedge clk); #1;
        in_expr = 95'({5'h12, 5'h11, 5'h02, 5'h05, 5'h0F}); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        in_expr = 95'({5'h10, 5'h03, 5'h04}); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got busy=%b ov=%b, want 0 0", busy, out_valid);
        end
        #2 rst = 1'b0;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_valid) strobes++;
        end
        total++;
        if (strobes != 0) begin
            bad++;
            $display("FAIL abort_no_strobe: got strobes=%0d, want 0", strobes);
        end
        send(95'({5'h12, 5'h11, 5'h02, 5'h05, 5'h0F}), o, er, lat);
        total++;
        if (o !== 41'(-45) || er !== 1'b0 || lat != 6) begin
            bad++;
            $display("FAIL after_abort: got out=%0d err=%b lat=%0d, want out=-45 err=0 lat=6", $signed(o), er, lat);
        end
        $display("reset abort: out=%0d err=%b lat=%0d", $signed(o), er, lat);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_after_reset();
        test_vectors();
        test_busy();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
